// File: rtl/sva_stim_pkg.sv
// Shared types for the SVA stimulus generator: FSM state encoding and the
// default-width command record queued in the generator FIFO.
package sva_stim_pkg;

    localparam int SEQ_GAP_W = 8;
    localparam int SEQ_REP_W = 8;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_GAP  = 2'd1,
        G_HIT  = 2'd2
    } gen_state_t;

    typedef struct packed {
        logic [SEQ_GAP_W-1:0] gap;
        logic [SEQ_REP_W-1:0] rep;
    } seq_cmd_t;

endpackage

// File: rtl/sva_cmd_fifo.sv
// Show-ahead synchronous command FIFO; the head entry is visible on rd_data
// whenever empty is low so the generator can pop and load in one cycle.
module sva_cmd_fifo
    import sva_stim_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type item_t = seq_cmd_t
) (
    input  logic  gclk,
    input  logic  grst,
    input  logic  push,
    input  logic  pop,
    input  item_t wr_data,
    output item_t rd_data,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    item_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sva_seq_gen.sv
// Stimulus generator for the SVA property checkers: plays "!a for gap cycles,
// then a" patterns and predicts when and how many checker threads succeed.
//
// state  | meaning
// G_IDLE | nothing executing; pop the FIFO head when one is queued
// G_GAP  | driving a=0, gap_ctr counts the remaining gap cycles
// G_HIT  | driving a=1 for one cycle; repeat, chain next command, or idle
module sva_seq_gen
    import sva_stim_pkg::*;
#(
    parameter int GAP_WIDTH   = 8,
    parameter int REP_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int EXP_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 gclk,
    input  logic                 grst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [GAP_WIDTH-1:0] cmd_gap,
    input  logic [REP_WIDTH-1:0] cmd_rep,
    output logic                 a,
    output logic                 busy,
    output logic                 exp_succ,
    output logic [GAP_WIDTH:0]   exp_count,
    output logic [CNT_WIDTH-1:0] seq_cnt
);

    typedef struct packed {
        logic [GAP_WIDTH-1:0] gap;
        logic [REP_WIDTH-1:0] rep;
    } cmd_t;

    cmd_t                 wr_cmd;
    cmd_t                 head;
    logic                 full;
    logic                 empty;
    logic                 pop;

    gen_state_t           state_q;
    gen_state_t           state_d;
    logic [GAP_WIDTH-1:0] gap_ctr;
    logic [GAP_WIDTH-1:0] gap_ctr_d;
    logic [REP_WIDTH-1:0] rep_ctr;
    logic [REP_WIDTH-1:0] rep_ctr_d;
    logic [GAP_WIDTH-1:0] cur_gap;
    logic [GAP_WIDTH-1:0] cur_gap_d;

    logic                 hit;
    logic [GAP_WIDTH:0]   hit_count;

    assign wr_cmd    = '{gap: cmd_gap, rep: cmd_rep};
    assign cmd_ready = !full;

    sva_cmd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .item_t (cmd_t)
    ) u_fifo (
        .gclk    (gclk),
        .grst    (grst),
        .push    (cmd_valid),
        .pop     (pop),
        .wr_data (wr_cmd),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    function automatic gen_state_t entry_state(input logic [GAP_WIDTH-1:0] g,
                                               input logic [REP_WIDTH-1:0] r);
        if (r == '0) begin
            return G_IDLE;
        end else if (g == '0) begin
            return G_HIT;
        end
        return G_GAP;
    endfunction

    always_comb begin
        state_d   = state_q;
        gap_ctr_d = gap_ctr;
        rep_ctr_d = rep_ctr;
        cur_gap_d = cur_gap;
        pop       = 1'b0;
        case (state_q)
            G_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    cur_gap_d = head.gap;
                    gap_ctr_d = head.gap;
                    rep_ctr_d = head.rep;
                    state_d   = entry_state(head.gap, head.rep);
                end
            end
            G_GAP: begin
                if (gap_ctr == GAP_WIDTH'(1)) begin
                    state_d = G_HIT;
                end else begin
                    gap_ctr_d = gap_ctr - GAP_WIDTH'(1);
                end
            end
            G_HIT: begin
                if (rep_ctr != REP_WIDTH'(1)) begin
                    rep_ctr_d = rep_ctr - REP_WIDTH'(1);
                    if (cur_gap != '0) begin
                        gap_ctr_d = cur_gap;
                        state_d   = G_GAP;
                    end
                end else if (!empty) begin
                    // Chain straight into the next command without an idle bubble.
                    pop       = 1'b1;
                    cur_gap_d = head.gap;
                    gap_ctr_d = head.gap;
                    rep_ctr_d = head.rep;
                    state_d   = entry_state(head.gap, head.rep);
                end else begin
                    state_d = G_IDLE;
                end
            end
            default: begin
                state_d = G_IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_q <= G_IDLE;
            gap_ctr <= '0;
            rep_ctr <= '0;
            cur_gap <= '0;
            a       <= 1'b0;
            seq_cnt <= '0;
        end else begin
            state_q <= state_d;
            gap_ctr <= gap_ctr_d;
            rep_ctr <= rep_ctr_d;
            cur_gap <= cur_gap_d;
            a       <= (state_d == G_HIT);
            if (hit) begin
                seq_cnt <= seq_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign busy      = (state_q != G_IDLE) || !empty;
    assign hit       = (state_q == G_HIT);
    assign hit_count = {1'b0, cur_gap} + (GAP_WIDTH+1)'(1);

    generate
        if (EXP_LATENCY == 0) begin : g_exp_comb
            assign exp_succ  = hit;
            assign exp_count = hit ? hit_count : '0;
        end else begin : g_exp_pipe
            logic [EXP_LATENCY-1:0] vld_pipe;
            logic [GAP_WIDTH:0]     cnt_pipe [EXP_LATENCY];

            always_ff @(posedge gclk or posedge grst) begin
                if (grst) begin
                    vld_pipe <= '0;
                    for (int i = 0; i < EXP_LATENCY; i++) begin
                        cnt_pipe[i] <= '0;
                    end
                end else begin
                    vld_pipe[0] <= hit;
                    cnt_pipe[0] <= hit ? hit_count : '0;
                    for (int i = 1; i < EXP_LATENCY; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        cnt_pipe[i] <= cnt_pipe[i-1];
                    end
                end
            end

            assign exp_succ  = vld_pipe[EXP_LATENCY-1];
            assign exp_count = cnt_pipe[EXP_LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_sva_seq_gen.sv
// Directed bench for sva_seq_gen: per-cycle vector table for the basic
// patterns, then hand-written FIFO back-pressure and mid-run reset sequences.
module tb_sva_seq_gen;

    logic        gclk;
    logic        grst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_gap;
    logic [7:0]  cmd_rep;
    logic        a;
    logic        busy;
    logic        exp_succ;
    logic [8:0]  exp_count;
    logic [15:0] seq_cnt;

    int tests = 0;
    int fails = 0;

    sva_seq_gen #(
        .GAP_WIDTH   (8),
        .REP_WIDTH   (8),
        .FIFO_DEPTH  (4),
        .EXP_LATENCY (1),
        .CNT_WIDTH   (16)
    ) dut (
        .gclk      (gclk),
        .grst      (grst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_gap   (cmd_gap),
        .cmd_rep   (cmd_rep),
        .a         (a),
        .busy      (busy),
        .exp_succ  (exp_succ),
        .exp_count (exp_count),
        .seq_cnt   (seq_cnt)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Passive monitor: counts hits and predicted successes, checks hit spacing.
    int          cyc = 0;
    int          hits = 0;
    int          succ_n = 0;
    int          bad_succ = 0;
    int          bad_ivl = 0;
    int          last_hit = 0;
    logic        have_last = 1'b0;
    logic        ivl_en = 1'b0;
    logic [8:0]  mon_exp_cnt = 9'd0;

    always @(negedge gclk) begin
        cyc = cyc + 1;
        if (!ivl_en) have_last = 1'b0;
        if (a) begin
            hits = hits + 1;
            if (ivl_en) begin
                if (have_last && (cyc - last_hit) != 6) bad_ivl = bad_ivl + 1;
                have_last = 1'b1;
                last_hit  = cyc;
            end
        end
        if (exp_succ) begin
            succ_n = succ_n + 1;
            if (exp_count != mon_exp_cnt) bad_succ = bad_succ + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  g;
        logic [7:0]  r;
        logic        ea;
        logic        es;
        logic [8:0]  ec;
        logic        eb;
        logic        er;
        logic [15:0] eq;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic v, input int g, input int r,
                                input logic ea, input logic es, input int ec,
                                input logic eb, input logic er, input int eq);
        vec_t t;
        t.v  = v;
        t.g  = 8'(g);
        t.r  = 8'(r);
        t.ea = ea;
        t.es = es;
        t.ec = 9'(ec);
        t.eb = eb;
        t.er = er;
        t.eq = 16'(eq);
        return t;
    endfunction

    int   accepted;
    int   acc_at_low;
    logic saw_low;
    int   w;
    int   s_hits;
    int   s_succ;
    int   s_bad;
    logic found;

    initial begin
        // gap=0 rep=1
        vecs[0]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 0, 1, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 1, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        // gap=3 rep=2
        vecs[5]  = mk(1, 3, 2, 0, 0, 0, 0, 1, 1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[10] = mk(0, 0, 0, 1, 0, 0, 1, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 1, 4, 1, 1, 2);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 2);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 2);
        vecs[14] = mk(0, 0, 0, 1, 0, 0, 1, 1, 2);
        vecs[15] = mk(0, 0, 0, 0, 1, 4, 0, 1, 3);
        // gap=1 rep=1 chained into gap=0 rep=1
        vecs[16] = mk(1, 1, 1, 0, 0, 0, 0, 1, 3);
        vecs[17] = mk(1, 0, 1, 0, 0, 0, 1, 1, 3);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 3);
        vecs[19] = mk(0, 0, 0, 1, 0, 0, 1, 1, 3);
        vecs[20] = mk(0, 0, 0, 1, 1, 2, 1, 1, 4);
        vecs[21] = mk(0, 0, 0, 0, 1, 1, 0, 1, 5);
        // gap=7 rep=0 discarded, then gap=0 rep=1
        vecs[22] = mk(1, 7, 0, 0, 0, 0, 0, 1, 5);
        vecs[23] = mk(1, 0, 1, 0, 0, 0, 1, 1, 5);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 1, 1, 5);
        vecs[25] = mk(0, 0, 0, 1, 0, 0, 1, 1, 5);
        vecs[26] = mk(0, 0, 0, 0, 1, 1, 0, 1, 6);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 1, 6);

        grst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_gap   = 8'd0;
        cmd_rep   = 8'd0;
        repeat (3) @(negedge gclk);
        chk("reset a", 32'(a), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset exp_succ", 32'(exp_succ), 0);
        chk("reset seq_cnt", 32'(seq_cnt), 0);
        grst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge gclk);
            chk($sformatf("row%0d a", i), 32'(a), 32'(vecs[i].ea));
            chk($sformatf("row%0d exp_succ", i), 32'(exp_succ), 32'(vecs[i].es));
            chk($sformatf("row%0d exp_count", i), 32'(exp_count), 32'(vecs[i].ec));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].eb));
            chk($sformatf("row%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].er));
            chk($sformatf("row%0d seq_cnt", i), 32'(seq_cnt), 32'(vecs[i].eq));
            cmd_valid = vecs[i].v;
            cmd_gap   = vecs[i].g;
            cmd_rep   = vecs[i].r;
        end

        // Six gap=5 rep=1 commands offered back to back against a 4-deep FIFO.
        s_hits      = hits;
        s_succ      = succ_n;
        s_bad       = bad_succ;
        mon_exp_cnt = 9'd6;
        ivl_en      = 1'b1;
        accepted    = 0;
        acc_at_low  = -1;
        saw_low     = 1'b0;
        cmd_gap     = 8'd5;
        cmd_rep     = 8'd1;
        cmd_valid   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = 0;
            while (!cmd_ready && w < 60) begin
                if (!saw_low) begin
                    saw_low    = 1'b1;
                    acc_at_low = accepted;
                end
                @(negedge gclk);
                w++;
            end
            if (!cmd_ready) begin
                chk($sformatf("fifo push%0d timeout", k), 32'(cmd_ready), 1);
            end else begin
                accepted++;
            end
            @(negedge gclk);
        end
        cmd_valid = 1'b0;
        chk("fifo ready went low", 32'(saw_low), 1);
        chk("fifo accepted before full", 32'(acc_at_low), 5);
        chk("fifo accepted total", 32'(accepted), 6);
        w = 0;
        while (busy && w < 100) begin
            @(negedge gclk);
            w++;
        end
        chk("fifo drain busy", 32'(busy), 0);
        repeat (3) @(negedge gclk);
        ivl_en = 1'b0;
        chk("fifo hits", 32'(hits - s_hits), 6);
        chk("fifo exp_succ pulses", 32'(succ_n - s_succ), 6);
        chk("fifo exp_count errors", 32'(bad_succ - s_bad), 0);
        chk("fifo hit spacing errors", 32'(bad_ivl), 0);
        chk("fifo seq_cnt", 32'(seq_cnt), 12);

        // Reset in the middle of a gap=10 command with two more queued.
        cmd_valid = 1'b1;
        cmd_gap   = 8'd10;
        cmd_rep   = 8'd1;
        @(negedge gclk);
        cmd_gap   = 8'd0;
        @(negedge gclk);
        @(negedge gclk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge gclk);
        chk("rst1 busy before", 32'(busy), 1);
        chk("rst1 a before", 32'(a), 0);
        #2 grst = 1'b1;
        #1;
        s_hits = hits;
        s_succ = succ_n;
        chk("rst1 a", 32'(a), 0);
        chk("rst1 busy", 32'(busy), 0);
        chk("rst1 cmd_ready", 32'(cmd_ready), 1);
        chk("rst1 seq_cnt", 32'(seq_cnt), 0);
        @(negedge gclk);
        grst = 1'b0;
        repeat (20) @(negedge gclk);
        chk("rst1 hits after", 32'(hits - s_hits), 0);
        chk("rst1 exp_succ after", 32'(succ_n - s_succ), 0);
        chk("rst1 busy after", 32'(busy), 0);
        chk("rst1 cmd_ready after", 32'(cmd_ready), 1);
        chk("rst1 seq_cnt after", 32'(seq_cnt), 0);

        // Reset while a=1 with an exp_succ already in flight.
        cmd_valid = 1'b1;
        cmd_gap   = 8'd0;
        cmd_rep   = 8'd3;
        @(negedge gclk);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge gclk);
            if (a) found = 1'b1;
        end
        chk("rst2 hit seen", 32'(found), 1);
        #2 grst = 1'b1;
        #1;
        s_hits = hits;
        s_succ = succ_n;
        chk("rst2 a", 32'(a), 0);
        chk("rst2 exp_succ", 32'(exp_succ), 0);
        @(negedge gclk);
        grst = 1'b0;
        repeat (10) @(negedge gclk);
        chk("rst2 hits after", 32'(hits - s_hits), 0);
        chk("rst2 exp_succ after", 32'(succ_n - s_succ), 0);
        chk("rst2 seq_cnt after", 32'(seq_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sva_seq_gen.md
Name: sva_seq_gen

Overview:
- Stimulus-side counterpart to the team's SVA-to-FSM property checkers.
- Drives the checked input `a` on gclk with programmed "!a for GAP cycles, then a" sequences, so each checker thread walks S0 -> S1* -> SEND.
- Emits the expected success timing and count for a scoreboard to compare against checker `succ` pulses.
- Sits in the testbench/emulation harness next to the checker and shares its gclk/grst domain.

Parameters:
- GAP_WIDTH, 8, width of the gap-length field (cycles of a=0 before the hit).
- REP_WIDTH, 8, width of the repetition-count field.
- FIFO_DEPTH, 4, number of pending commands held (power of 2, ≥2).
- EXP_LATENCY, 1, gclk cycles from a=1 visible to exp_succ, matching the checker's input register; 0 allowed.
- CNT_WIDTH, 16, width of seq_cnt.

Ports:
- gclk  in  1  user clock.
- grst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready at a gclk edge.
- cmd_gap  in  GAP_WIDTH  number of a=0 cycles before the hit.
- cmd_rep  in  REP_WIDTH  number of times the gap+hit pattern is repeated.
- a  out  1  registered stimulus to the checker.
- busy  out  1  command executing or FIFO non-empty.
- exp_succ  out  1  one-cycle pulse: checker is expected to report success.
- exp_count  out  GAP_WIDTH+1  number of threads expected to succeed with exp_succ (gap+1); 0 when exp_succ is low.
- seq_cnt  out  CNT_WIDTH  total hit cycles driven, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, grst=1):
  - a=0, exp_succ=0, exp_count=0, seq_cnt=0, busy=0.
  - cmd_ready=1 after release.
  - FIFO emptied, delay line cleared, FSM in G_IDLE.
- Command FIFO:
  - cmd_ready = !full.
  - Push on valid&ready.
  - Push and pop in the same cycle are legal when not full.
  - While full, cmd_ready=0 and cmd_valid is ignored.
- FSM states: G_IDLE, G_GAP, G_HIT. `a` is registered from the next state: a=1 exactly in G_HIT.
- G_IDLE:
  - FIFO empty: stay, a=0.
  - FIFO non-empty: pop and load gap_ctr=cmd_gap, rep_ctr=cmd_rep, then go to:
    - G_HIT if gap=0 and rep≠0;
    - G_GAP if gap≠0 and rep≠0;
    - stay in G_IDLE if rep=0 (command discarded, one idle cycle, no hit, seq_cnt unchanged).
- Latency: a command pushed at edge E is popped at E+1 (if the FIFO was empty and the FSM idle); first stimulus value is visible after E+1.
- G_GAP:
  - a=0 for exactly `gap` cycles (down-counter).
  - On the last gap cycle, go to G_HIT.
- G_HIT:
  - a=1 for exactly one cycle; seq_cnt+1; rep_ctr-1.
  - rep_ctr>1: reload gap_ctr from the latched gap and go to G_GAP, or stay in G_HIT if gap=0. Back-to-back, no idle cycle.
  - Last repetition with FIFO non-empty: pop the next command in the same cycle and transition directly. No a=0 bubble unless the next gap≠0.
  - Last repetition with FIFO empty: go to G_IDLE.
- Expected result:
  - Every cycle the checker starts a new thread; a hit therefore completes gap+1 live threads.
  - In the hit cycle, the generator forms {1, gap+1} and passes it through an EXP_LATENCY-stage register pipeline to exp_succ/exp_count.
  - EXP_LATENCY=0 means combinational alignment with a.
- Counters:
  - gap_ctr and rep_ctr are unsigned and never wrap.
  - gap_ctr uses the full GAP_WIDTH range (gap up to 2^GAP_WIDTH-1).
  - exp_count is GAP_WIDTH+1 bits so that gap+1 does not overflow.
- busy = (state≠G_IDLE) | !empty.
- Reset mid-operation: all state lost, including queued commands and in-flight exp pipeline entries; no exp_succ after reset.

Decomposition:
- Package sva_stim_pkg:
  - gen_state_t enum {G_IDLE, G_GAP, G_HIT};
  - packed struct seq_cmd_t {gap, rep}, parameterised via package localparams matching the defaults.
- Sub-module sva_cmd_fifo: synchronous FIFO on gclk/grst with push/pop/full/empty, storing seq_cmd_t.
- FSM, counters and exp pipeline live in sva_seq_gen.

Test Plan:
- gap=0, rep=1 → a=1 for exactly one cycle; exp_succ one cycle later (EXP_LATENCY=1) with exp_count=1; seq_cnt=1.
- gap=3, rep=2 → a = 0,0,0,1,0,0,0,1; two exp_succ pulses each with exp_count=4; seq_cnt=2; busy drops the cycle after the second hit.
- gap=1 rep=1 followed by queued gap=0 rep=1 → a = 0,1,1 with no idle bubble; exp_count 2 then 1.
- Push 6 commands (gap=5, rep=1) while the first executes → cmd_ready low once 4 are pending; accepted commands execute in order; none lost.
- gap=7, rep=0 → no a pulse, no exp_succ, seq_cnt unchanged; the following gap=0 rep=1 hits one cycle later than it would without the rep=0 command.
- grst asserted mid-G_GAP of gap=10 with 2 queued → a=0 immediately; FIFO empty; no exp_succ after release; cmd_ready=1; seq_cnt=0.
